// File: rtl/dmem_banked_if.sv
// Request/response bus for dmem_banked.
//   master : drives req_valid/req_we/req_be/req_addr/req_wdata; sees req_ready and rsp_*
//   slave  : the memory; drives req_ready, rsp_valid, rsp_data, rsp_err
interface dmem_banked_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned NBYTE = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [NBYTE-1:0]  req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dmem_banked.sv
// Parametrised data memory with per-byte write enables, one-cycle registered read,
// out-of-range error responses and a zeroing sweep after reset or on clr.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, starts the zeroing sweep
//   clr  : single-cycle request to re-zero the memory (honoured only when idle)
//   busy : sweep in progress, no requests accepted
//   bus  : request/response port (slave side)
module dmem_banked #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic         busy,
  dmem_banked_if.slave bus
);
  localparam int unsigned NBYTE = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  typedef enum logic {StClear, StIdle} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic             in_range;
  logic             accept;
  logic             wr_acc;
  logic [IDX_W-1:0] idx;

  // Compare one bit wider so DEPTH == 2**ADDR_W is representable.
  assign in_range = ({1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH));
  assign idx      = bus.req_addr[IDX_W-1:0];

  assign busy          = (state_q == StClear);
  assign bus.req_ready = (state_q == StIdle) && !clr;
  assign accept        = bus.req_valid && bus.req_ready && !rst;
  assign wr_acc        = accept && bus.req_we && in_range;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  // Storage: no reset, contents defined by the sweep. Sweep and writes never overlap
  // because requests are only accepted in StIdle.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (bus.req_be[i]) begin
          mem_q[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StClear;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StClear: begin
          if (ptr_q == LastIdx) begin
            state_q <= StIdle;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        StIdle: begin
          if (clr) begin
            state_q <= StClear;
            ptr_q   <= '0;
          end else if (accept) begin
            if (!in_range) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else if (!bus.req_we) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= mem_q[idx];
            end
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_banked.sv
module tb_dmem_banked;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 12;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] last_data;

  dmem_banked_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dmem_banked #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  // Count cycles busy stays high; req_ready must be low on each of them.
  task automatic wait_clear(input string tag);
    int n;
    int rdy_hi;
    n = 0;
    rdy_hi = 0;
    while (busy === 1'b1 && n < 200) begin
      if (bus.req_ready !== 1'b0) rdy_hi++;
      n++;
      tick();
    end
    chk({tag, ":busy_cycles"}, n, DEPTH);
    chk({tag, ":ready_in_clear"}, rdy_hi, 0);
    chk({tag, ":ready_after"}, bus.req_ready, 1'b1);
  endtask

  task automatic do_req(input logic we, input logic [3:0] be, input logic [3:0] addr,
                        input logic [31:0] wd, input string tag);
    logic        oob;
    logic        exp_v;
    logic [31:0] exp_d;
    logic [31:0] mask;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    chk({tag, ":ready"}, bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    oob   = (int'(addr) >= DEPTH);
    exp_v = oob || !we;
    if (oob)      exp_d = 32'h0;
    else if (!we) exp_d = model[addr];
    else          exp_d = last_data;
    chk({tag, ":rsp_valid"}, bus.rsp_valid, exp_v);
    if (exp_v) chk({tag, ":rsp_err"}, bus.rsp_err, oob);
    chk({tag, ":rsp_data"}, bus.rsp_data, exp_d);
    if (exp_v) last_data = exp_d;
    if (we && !oob) begin
      mask = 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
      model[addr] = (model[addr] & ~mask) | (wd & mask);
    end
  endtask

  task automatic idle_chk(input string tag);
    tick();
    chk({tag, ":no_rsp"}, bus.rsp_valid, 1'b0);
    chk({tag, ":hold"}, bus.rsp_data, last_data);
  endtask

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_be    = 4'h0;
    bus.req_addr  = 4'h0;
    bus.req_wdata = 32'h0;
    zero_model();
    last_data = 32'h0;

    // Reset and initial sweep; a write held on the bus during the sweep must be ignored.
    tick();
    rst = 1'b0;
    chk("reset:busy", busy, 1'b1);
    chk("reset:ready", bus.req_ready, 1'b0);
    chk("reset:rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset:rsp_err", bus.rsp_err, 1'b0);
    chk("reset:rsp_data", bus.rsp_data, 32'h0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_be    = 4'hF;
    bus.req_addr  = 4'd1;
    bus.req_wdata = 32'hFFFF_FFFF;
    wait_clear("init");
    bus.req_valid = 1'b0;
    chk("init:no_rsp", bus.rsp_valid, 1'b0);
    for (int a = 0; a < DEPTH; a++) do_req(1'b0, 4'h0, 4'(a), 32'h0, "init_read");
    idle_chk("pulse");

    // Byte lanes
    do_req(1'b1, 4'b1111, 4'd5, 32'hDEAD_BEEF, "be_w1");
    do_req(1'b1, 4'b0101, 4'd5, 32'h1122_3344, "be_w2");
    do_req(1'b0, 4'h0, 4'd5, 32'h0, "be_rd");
    chk("be_const", bus.rsp_data, 32'hDE22_BE44);

    // Back-to-back read-after-write
    do_req(1'b1, 4'hF, 4'd3, 32'h0000_00A5, "raw_w1");
    do_req(1'b0, 4'h0, 4'd3, 32'h0, "raw_r1");
    chk("raw_const1", bus.rsp_data, 32'h0000_00A5);
    do_req(1'b1, 4'hF, 4'd3, 32'h0000_005A, "raw_w2");
    do_req(1'b0, 4'h0, 4'd3, 32'h0, "raw_r2");
    chk("raw_const2", bus.rsp_data, 32'h0000_005A);

    // Out of range, then boundary word
    do_req(1'b1, 4'hF, 4'd11, 32'hCAFE_F00D, "oob_prep");
    do_req(1'b1, 4'hF, 4'd13, 32'h0000_00FF, "oob_w");
    do_req(1'b0, 4'h0, 4'd13, 32'h0, "oob_r");
    do_req(1'b0, 4'h0, 4'd12, 32'h0, "oob_r12");
    do_req(1'b0, 4'h0, 4'd11, 32'h0, "edge_r11");
    chk("edge_const", bus.rsp_data, 32'hCAFE_F00D);

    // Zero byte-enable write is an accepted no-op
    do_req(1'b1, 4'h0, 4'd5, 32'h0BAD_0BAD, "be0_w");
    do_req(1'b0, 4'h0, 4'd5, 32'h0, "be0_r");
    idle_chk("be0_idle");

    // Random traffic against the model
    for (int k = 0; k < 60; k++) begin
      do_req(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom_range(0, 15)),
             $urandom, "rand");
      if ($urandom_range(0, 4) == 0) idle_chk("rand_idle");
    end

    // clr beats a simultaneous request
    do_req(1'b1, 4'hF, 4'd2, 32'h0000_0077, "clr_fill");
    clr           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'd2;
    #1;
    chk("clr:ready_low", bus.req_ready, 1'b0);
    tick();
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    chk("clr:no_rsp", bus.rsp_valid, 1'b0);
    chk("clr:busy", busy, 1'b1);
    zero_model();
    wait_clear("clr");
    do_req(1'b0, 4'h0, 4'd2, 32'h0, "clr_retry");
    chk("clr_const", bus.rsp_data, 32'h0);

    // Reset in the middle of a sweep restarts it
    for (int a = 0; a < DEPTH; a++) do_req(1'b1, 4'hF, 4'(a), $urandom | 32'h1, "mid_fill");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    zero_model();
    for (int c = 0; c < 7; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_data = 32'h0;
    chk("mid:rsp_data", bus.rsp_data, 32'h0);
    wait_clear("mid");
    for (int a = 0; a < DEPTH; a++) do_req(1'b0, 4'h0, 4'(a), 32'h0, "mid_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_banked.md
Name: dmem_banked

Overview:
- Parametrised data memory that replaces the fixed 8-bit x 16-address data memory in the microcontroller datapath.
- Configurable word width and depth, per-byte write enables and a registered read.
- Uses a valid/ready request port and a response port that flags out-of-range accesses.
- Has a built-in clear sequencer: memory contents are defined (zero) after reset, or on command, before any access is accepted.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8
ADDR_W, 8, address width in bits
DEPTH, 256, number of implemented words; 1 <= DEPTH <= 2**ADDR_W
NBYTE, DATA_W/8, derived (localparam): number of byte lanes

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
clr  in  1  single-cycle request to re-zero the whole memory
req_valid  in  1  access request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_be  in  NBYTE  byte-lane write enables; ignored on reads
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read response / error valid, one-cycle pulse
rsp_data  out  DATA_W  read data
rsp_err  out  1  accompanying access was out of range
busy  out  1  clear sequence in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- States: CLEAR, IDLE.
- Reset:
  - rst=1 forces state=CLEAR, clear pointer=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - busy=1 and req_ready=0 from the first post-reset cycle.
  - rst asserted mid-clear restarts the sweep at address 0.
- CLEAR:
  - Each cycle writes 0 to word[ptr] and increments ptr.
  - When ptr==DEPTH-1 is written, go to IDLE on the next edge. CLEAR lasts exactly DEPTH cycles.
  - busy=1 and req_ready=0 throughout; req_valid is ignored and nothing is queued.
- IDLE:
  - busy=0.
  - req_ready = (state==IDLE) && !clr, combinational.
  - Handshake: a request is accepted when req_valid && req_ready at a rising edge.
  - clr=1 in IDLE moves to CLEAR (ptr=0) on the next edge. clr takes priority over a simultaneous request, which is not accepted (req_ready=0). clr during CLEAR is ignored.
- Write accept:
  - For each lane i with req_be[i]=1, word[addr][8i+7:8i] <= req_wdata[8i+7:8i]. Other lanes are unchanged.
  - Produces no rsp_valid unless out of range.
- Read accept: next cycle rsp_valid=1 and rsp_data=word[addr]. Latency is exactly 1 cycle.
- Back-to-back:
  - One accepted request per cycle, with no bubbles.
  - A read in the cycle immediately after a write to the same address returns the new data.
  - rsp_data holds its last value while rsp_valid=0.
- Out of range (addr >= DEPTH):
  - Write: no array change; next cycle rsp_valid=1, rsp_err=1, rsp_data=0.
  - Read: next cycle rsp_valid=1, rsp_err=1, rsp_data=0.
  - rsp_err=0 on every in-range response.
- req_be=0 write: legal no-op and accepted.
- Address wrap: none. Addresses never wrap modulo DEPTH.
- Storage: memory inferable as synchronous-write/registered-read RAM. No reset on the array itself beyond the CLEAR sweep.

Test Plan:
- Reset/clear timing: DATA_W=8, DEPTH=16; pulse rst 1 cycle -> busy=1 and req_ready=0 for exactly 16 cycles, then busy=0; reads of addr 0..15 all return 0x00 with rsp_err=0, each 1 cycle after accept.
- Byte enables: DATA_W=32; write addr 5 data 0xDEADBEEF be=4'b1111, then write addr 5 data 0x11223344 be=4'b0101; read addr 5 -> rsp_data=0xDE22BE44.
- Back-to-back RAW: write addr 3 = 0xA5, read addr 3 on the very next cycle, then write 0x5A and read -> responses 0xA5 then 0x5A; req_ready stays 1 throughout.
- Out of range: DEPTH=12, ADDR_W=4; write addr 13 = 0xFF -> next cycle rsp_valid=1, rsp_err=1. Read addr 13 -> rsp_err=1, rsp_data=0. Read addr 11 -> rsp_err=0 with original contents.
- clr vs request: fill addr 2 = 0x77; assert clr and req_valid(read addr 2) in the same cycle -> request not accepted, CLEAR runs DEPTH cycles; the retried read returns 0x00.
- Reset mid-clear: assert rst at clear cycle 7 of 16 -> sweep restarts; busy stays high 16 more cycles; all words read 0.
